// File: rtl/icache_tag_ram_ctrl_pkg.sv
// Shared types for the instruction-cache tag RAM controller: sequencer states
// and tag word field positions.
package icache_tag_ctrl_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    SWEEP = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int unsigned VALID_BIT = 0;

endpackage

// File: rtl/icache_tag_ram_ctrl_if.sv
// Bus bundle between the cache controller (master) and the tag RAM controller
// (slave), including the tag RAM side of the controller.
interface icache_tag_ram_ctrl_if #(
  parameter int unsigned addr_width = 6,
  parameter int unsigned data_width = 7
);

  logic                  flush_req_i;
  logic                  flush_ack_o;
  logic                  busy_o;
  logic                  lkp_req_i;
  logic [addr_width-1:0] lkp_addr_i;
  logic                  lkp_gnt_o;
  logic                  lkp_rvalid_o;
  logic [data_width-1:0] lkp_rdata_o;
  logic                  wr_req_i;
  logic [addr_width-1:0] wr_addr_i;
  logic [data_width-1:0] wr_data_i;
  logic                  wr_gnt_o;
  logic                  mem_req_o;
  logic                  mem_write_o;
  logic [addr_width-1:0] mem_addr_o;
  logic [data_width-1:0] mem_wdata_o;
  logic [data_width-1:0] mem_rdata_i;

  modport slave (
    input  flush_req_i, lkp_req_i, lkp_addr_i, wr_req_i, wr_addr_i, wr_data_i, mem_rdata_i,
    output flush_ack_o, busy_o, lkp_gnt_o, lkp_rvalid_o, lkp_rdata_o, wr_gnt_o,
           mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output flush_req_i, lkp_req_i, lkp_addr_i, wr_req_i, wr_addr_i, wr_data_i, mem_rdata_i,
    input  flush_ack_o, busy_o, lkp_gnt_o, lkp_rvalid_o, lkp_rdata_o, wr_gnt_o,
           mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/icache_tag_ram_ctrl.sv
// Tag RAM sequencer/arbiter: clears the bank after reset and on flush, then
// shares the single port between lookups and refill writes.
//
// state | meaning
// START | reset state, no memory access
// SWEEP | writing '0 to index cnt, one entry per cycle
// RUN   | normal operation, lookup/write arbitration
module icache_tag_ram_ctrl
  import icache_tag_ctrl_pkg::*;
#(
  parameter int unsigned addr_width = 6,
  parameter int unsigned data_width = 7
) (
  input logic                 clk,
  input logic                 rst,
  icache_tag_ram_ctrl_if.slave bus
);

  localparam logic [addr_width-1:0] CNT_LAST = '1;

  state_t                state;
  logic [addr_width-1:0] cnt;
  logic                  prio_lkp;
  logic                  busy;
  logic                  flush_ack;
  logic                  lkp_rvalid;
  logic                  wr_gnt;
  logic                  lkp_gnt;

  // Writes win unless a lookup has already been passed over by a write.
  always_comb begin
    wr_gnt  = 1'b0;
    lkp_gnt = 1'b0;
    if (state == RUN) begin
      wr_gnt  = bus.wr_req_i && !(prio_lkp && bus.lkp_req_i);
      lkp_gnt = bus.lkp_req_i && !wr_gnt;
    end
  end

  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_write_o = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (state == SWEEP) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_write_o = 1'b1;
      bus.mem_addr_o  = cnt;
    end else if (wr_gnt) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_write_o = 1'b1;
      bus.mem_addr_o  = bus.wr_addr_i;
      bus.mem_wdata_o = bus.wr_data_i;
    end else if (lkp_gnt) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_addr_o  = bus.lkp_addr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= START;
      cnt        <= '0;
      prio_lkp   <= 1'b0;
      busy       <= 1'b1;
      flush_ack  <= 1'b0;
      lkp_rvalid <= 1'b0;
    end else begin
      flush_ack  <= 1'b0;
      lkp_rvalid <= lkp_gnt;
      case (state)
        START: begin
          state <= SWEEP;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        // Flush requests seen here are absorbed by the sweep in progress.
        SWEEP: begin
          if (cnt == CNT_LAST) begin
            state     <= RUN;
            busy      <= 1'b0;
            flush_ack <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (wr_gnt && bus.lkp_req_i) prio_lkp <= 1'b1;
          else if (lkp_gnt)            prio_lkp <= 1'b0;
          if (bus.flush_req_i) begin
            state <= SWEEP;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: state <= START;
      endcase
    end
  end

  assign bus.wr_gnt_o     = wr_gnt;
  assign bus.lkp_gnt_o    = lkp_gnt;
  assign bus.busy_o       = busy;
  assign bus.flush_ack_o  = flush_ack;
  assign bus.lkp_rvalid_o = lkp_rvalid;
  assign bus.lkp_rdata_o  = bus.mem_rdata_i;

endmodule
